// File: rtl/pp_accumulator.sv
// pp_accumulator
//   Consumer end of the SD4 MAC partial-product interface. Each accepted
//   {signed_pp, exp} term is aligned by its exponent and registered
//   (stage 1), then added into the frame accumulator (stage 2). After
//   NUM_PP terms the frame sum is published on a valid/ready output.
//
//   Build option: define PP_ACC_SATURATE_EN for saturating accumulation
//   with a sticky per-frame overflow flag. Otherwise the accumulator wraps
//   and out_overflow is tied low.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  term handshake (in_ready is registered)
//   signed_pp[4:0]     [4]=sign, [3]=hidden one, [2:0]=mantissa
//   exp[4:0]           left-shift amount, 0..31
//   clear              frame abort (ignored while a sum is pending)
//   out_valid/ready    sum handshake (out_valid is registered)
//   out_sum            signed frame sum, ACC_W bits
//   out_overflow       frame saturated (saturating build only)
//
// state | meaning
// ACCUM | accepting terms of the current frame
// DRAIN | final term in flight through the add stage
// DONE  | sum presented, waiting for out_ready
module pp_accumulator #(
    parameter int NUM_PP = 9,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       signed_pp,
    input  logic [4:0]       exp,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_overflow
);

`ifdef PP_ACC_SATURATE_EN
    // Two guard bits let stage 1 keep any term that could still cancel
    // against the accumulator; larger terms are pre-clamped.
    localparam int TERM_W = ACC_W + 2;
`else
    localparam int TERM_W = ACC_W;
`endif
    localparam logic [7:0] LAST_CNT = 8'(NUM_PP - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t            state;
    logic [7:0]        count;
    logic [TERM_W-1:0] term_in;
    logic [TERM_W-1:0] term_q;
    logic              term_valid;
    logic              term_last;
    logic              frame_done;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;

`ifdef PP_ACC_SATURATE_EN
    localparam int WIDE_W = ACC_W + 36;
    localparam int SUM_W  = ACC_W + 3;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [WIDE_W-1:0] mag_wide;
    logic [WIDE_W-1:0] term_wide;
    logic              term_fit;
    logic [SUM_W-1:0]  sum_wide;
    logic              sum_ovf;
    logic              sticky;
    logic              sticky_next;

    always_comb begin
        mag_wide  = WIDE_W'(signed_pp[3:0]) << exp;
        term_wide = signed_pp[4] ? -mag_wide : mag_wide;
        term_fit  = (term_wide[WIDE_W-1:TERM_W-1] == {(WIDE_W-TERM_W+1){term_wide[TERM_W-1]}});
        // An out-of-range term already exceeds any accumulator value, so
        // clamping it to the guard range keeps the overflow direction exact.
        if (term_fit) begin
            term_in = term_wide[TERM_W-1:0];
        end else if (signed_pp[4]) begin
            term_in = {1'b1, {(TERM_W-1){1'b0}}};
        end else begin
            term_in = {1'b0, {(TERM_W-1){1'b1}}};
        end
    end

    always_comb begin
        sum_wide    = {{3{acc[ACC_W-1]}}, acc} + {term_q[TERM_W-1], term_q};
        sum_ovf     = (sum_wide[SUM_W-1:ACC_W-1] != {4{sum_wide[ACC_W-1]}});
        sticky_next = sticky | sum_ovf;
        if (!sum_ovf) begin
            acc_next = sum_wide[ACC_W-1:0];
        end else if (sum_wide[SUM_W-1]) begin
            acc_next = ACC_MIN;
        end else begin
            acc_next = ACC_MAX;
        end
    end
`else
    logic [ACC_W-1:0] mag;

    always_comb begin
        mag      = ACC_W'(signed_pp[3:0]) << exp;
        term_in  = signed_pp[4] ? -mag : mag;
        acc_next = acc + term_q;
    end

    assign out_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            in_ready   <= 1'b0;
            count      <= '0;
            term_q     <= '0;
            term_valid <= 1'b0;
            term_last  <= 1'b0;
            frame_done <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
`ifdef PP_ACC_SATURATE_EN
            sticky       <= 1'b0;
            out_overflow <= 1'b0;
`endif
        end else begin
            term_valid <= 1'b0;
            term_last  <= 1'b0;
            frame_done <= 1'b0;

            if (term_valid) begin
                acc <= acc_next;
`ifdef PP_ACC_SATURATE_EN
                sticky <= sticky_next;
`endif
                if (term_last) begin
                    frame_done <= 1'b1;
                end
            end

            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (clear) begin
                        acc   <= '0;
                        count <= '0;
`ifdef PP_ACC_SATURATE_EN
                        sticky <= 1'b0;
`endif
                    end else if (in_valid && in_ready) begin
                        term_q     <= term_in;
                        term_valid <= 1'b1;
                        if (count == LAST_CNT) begin
                            term_last <= 1'b1;
                            count     <= '0;
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (clear) begin
                        acc        <= '0;
                        count      <= '0;
                        term_valid <= 1'b0;
                        term_last  <= 1'b0;
                        frame_done <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ACCUM;
`ifdef PP_ACC_SATURATE_EN
                        sticky <= 1'b0;
`endif
                    end else if (frame_done) begin
                        // The final add landed in acc on the previous edge;
                        // publish it and start the next frame from zero.
                        out_sum   <= acc;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        state     <= DONE;
`ifdef PP_ACC_SATURATE_EN
                        out_overflow <= sticky;
                        sticky       <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
`ifdef PP_ACC_SATURATE_EN
                        out_overflow <= 1'b0;
`endif
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// tb_pp_accumulator
//   Drives two pp_accumulator instances (ACC_W=32 and ACC_W=16, NUM_PP=9)
//   from the same stimulus and checks both against a frame-level model:
//   exact integer term values, then wrap or clamp at the output width.
module tb_pp_accumulator;
    localparam int NUM_PP = 9;
`ifdef PP_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  signed_pp = '0;
    logic [4:0]  pp_exp = '0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [31:0] sum_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [15:0] sum_b;

    int          checks = 0;
    int          errors = 0;
    longint      terms[$];

    always #5 clk = ~clk;

    pp_accumulator #(.NUM_PP(NUM_PP), .ACC_W(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .signed_pp(signed_pp), .exp(pp_exp), .clear(clear),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(sum_a),
        .out_overflow(ovf_a)
    );

    pp_accumulator #(.NUM_PP(NUM_PP), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .signed_pp(signed_pp), .exp(pp_exp), .clear(clear),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(sum_b),
        .out_overflow(ovf_b)
    );

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint term_val(input logic [4:0] pp, input logic [4:0] e);
        longint mag;
        mag = longint'(pp[3:0]) << e;
        return pp[4] ? -mag : mag;
    endfunction

    function automatic longint model_sum(input int w, output bit ovf);
        longint maxv, minv, m, acc;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        m    = longint'(1) << w;
        acc  = 0;
        ovf  = 1'b0;
        foreach (terms[i]) begin
            acc += terms[i];
            if (SAT) begin
                if (acc > maxv) begin
                    acc = maxv;
                    ovf = 1'b1;
                end else if (acc < minv) begin
                    acc = minv;
                    ovf = 1'b1;
                end
            end
        end
        if (!SAT) begin
            acc = acc % m;
            if (acc < 0) acc += m;
            if (acc > maxv) acc -= m;
        end
        return acc;
    endfunction

    task automatic check_ready(input string tag, input bit want);
        check({tag, "_rdy32"}, longint'(in_ready_a), longint'(want));
        check({tag, "_rdy16"}, longint'(in_ready_b), longint'(want));
    endtask

    task automatic check_valid(input string tag, input bit want);
        check({tag, "_vld32"}, longint'(out_valid_a), longint'(want));
        check({tag, "_vld16"}, longint'(out_valid_b), longint'(want));
    endtask

    task automatic check_result(input string tag, input longint w32, input bit o32,
                                input longint w16, input bit o16);
        check({tag, "_sum32"}, longint'($signed(sum_a)), w32);
        check({tag, "_sum16"}, longint'($signed(sum_b)), w16);
        check({tag, "_ovf32"}, longint'(ovf_a), longint'(o32));
        check({tag, "_ovf16"}, longint'(ovf_b), longint'(o16));
    endtask

    task automatic gen_beat(input int mode, input int i, output logic [4:0] pp, output logic [4:0] e);
        case (mode)
            0: begin pp = 5'b01000; e = 5'd0; end
            1: begin
                if (i == 0) begin pp = 5'b11010; e = 5'd3; end
                else if (i == 1) begin pp = 5'b01111; e = 5'd22; end
                else begin pp = 5'b00000; e = 5'd7; end
            end
            2: begin pp = 5'($urandom_range(0, 31)); e = 5'($urandom_range(0, 31)); end
            3: begin pp = 5'b01111; e = 5'd10; end
            4: begin pp = 5'b01000; e = 5'd1; end
            default: begin
                pp = {i[0], 1'b1, 3'($urandom_range(0, 7))};
                e  = 5'($urandom_range(0, 22));
            end
        endcase
    endtask

    task automatic send_beat(input logic [4:0] pp, input logic [4:0] e);
        signed_pp = pp;
        pp_exp    = e;
        in_valid  = 1'b1;
        check_ready("beat", 1'b1);
        tick;
        terms.push_back(term_val(pp, e));
        in_valid = 1'b0;
    endtask

    task automatic send_beats(input int mode, input int n, input bit gaps);
        logic [4:0] pp, e;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick;
                    check_ready("gap", 1'b1);
                end
            end
            gen_beat(mode, i, pp, e);
            send_beat(pp, e);
        end
    endtask

    // One full frame: beats, two-cycle latency, optional backpressure
    // (optionally with clear asserted while the sum waits), handshake.
    task automatic run_frame(input int mode, input bit gaps, input int hold, input bit clr_done);
        longint w32, w16;
        bit     o32, o16;
        terms.delete();
        out_ready = 1'b1;
        send_beats(mode, NUM_PP, gaps);
        w32 = model_sum(32, o32);
        w16 = model_sum(16, o16);
        // Keep offering beats while busy; none may be taken.
        in_valid  = 1'b1;
        signed_pp = 5'b01111;
        pp_exp    = 5'd20;
        check_ready("lat0", 1'b0);
        check_valid("lat0", 1'b0);
        tick;
        check_ready("lat1", 1'b0);
        check_valid("lat1", 1'b0);
        tick;
        check_ready("lat2", 1'b0);
        check_valid("lat2", 1'b1);
        check_result("lat2", w32, o32, w16, o16);
        if (hold > 0) begin
            out_ready = 1'b0;
            clear     = clr_done;
            repeat (hold) begin
                tick;
                check_ready("hold", 1'b0);
                check_valid("hold", 1'b1);
                check_result("hold", w32, o32, w16, o16);
            end
            clear     = 1'b0;
            out_ready = 1'b1;
        end
        tick;
        in_valid = 1'b0;
        check_ready("hs", 1'b1);
        check_valid("hs", 1'b0);
        check("hs_ovf32", longint'(ovf_a), 0);
        check("hs_ovf16", longint'(ovf_b), 0);
    endtask

    task automatic abort_frame(input bit use_rst);
        terms.delete();
        send_beats(2, 4, 1'b0);
        if (use_rst) begin
            rst = 1'b1;
            tick;
            check_ready("rst", 1'b0);
            check_valid("rst", 1'b0);
            check_result("rst", 0, 1'b0, 0, 1'b0);
            rst = 1'b0;
            tick;
            check_ready("rst_rel", 1'b1);
        end else begin
            clear     = 1'b1;
            in_valid  = 1'b1;
            signed_pp = 5'b01111;
            pp_exp    = 5'd5;
            tick;
            clear    = 1'b0;
            in_valid = 1'b0;
            check_ready("clr", 1'b1);
            check_valid("clr", 1'b0);
        end
        run_frame(4, 1'b0, 0, 1'b0);
    endtask

    task automatic drain_clear;
        terms.delete();
        send_beats(4, NUM_PP, 1'b0);
        check_ready("dclr0", 1'b0);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check_ready("dclr1", 1'b1);
        check_valid("dclr1", 1'b0);
        tick;
        check_ready("dclr2", 1'b1);
        check_valid("dclr2", 1'b0);
    endtask

    initial begin
        tick;
        tick;
        check_ready("reset", 1'b0);
        check_valid("reset", 1'b0);
        check_result("reset", 0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        tick;
        check_ready("reset_rel", 1'b1);

        run_frame(0, 1'b0, 0, 1'b0);
        run_frame(1, 1'b0, 0, 1'b0);
        run_frame(2, 1'b1, 5, 1'b0);
        run_frame(2, 1'b1, 0, 1'b0);
        abort_frame(1'b1);
        abort_frame(1'b0);
        drain_clear;
        run_frame(4, 1'b0, 0, 1'b0);
        run_frame(3, 1'b0, 2, 1'b0);
        run_frame(2, 1'b1, 3, 1'b1);
        for (int f = 0; f < 3; f++) run_frame(5, 1'b0, 0, 1'b0);
        for (int f = 0; f < 10; f++) run_frame(2, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_accumulator.md
Name: pp_accumulator

Overview:
- Consumer end of the SD4 MAC partial-product interface: accepts {signed_pp, exp} terms from the partial product generator one per handshake.
- Aligns each term by its exponent, then accumulates a frame of NUM_PP terms (one convolution window) into a signed fixed-point sum.
- Presents the sum on a valid/ready output toward the activation/requantisation stage.

Parameters:
- NUM_PP, 9, terms per frame (3x3 kernel); legal range 1..255.
- ACC_W, 32, accumulator and output width, signed two's complement; minimum 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  term present.
- in_ready  output  1  accumulator can accept a term.
- signed_pp  input  5  [4]=sign, [3]=hidden one, [2:0]=mantissa; all-zero encodes a zero term.
- exp  input  5  unsigned left-shift amount; 0..22 from the generator, 0..31 handled.
- clear  input  1  synchronous frame abort; discards the partial sum and count.
- out_valid  output  1  frame sum available.
- out_ready  input  1  downstream accepts the sum.
- out_sum  output  ACC_W  signed frame sum.
- out_overflow  output  1  frame overflowed (see Optional Feature).

Behaviour:
- Reset, and the cycle after it: in_ready=0, out_valid=0, out_sum=0, out_overflow=0. Count, accumulator and align stage are cleared; state=ACCUM. in_ready=1 from the first cycle after rst deasserts.
- Term value:
  - mag = signed_pp[3:0] zero-extended, shifted left by exp.
  - term = signed_pp[4] ? -mag : +mag.
  - Computed at ACC_W+1 bits, then truncated to ACC_W. Shift bits beyond ACC_W are discarded.
  - All-zero signed_pp gives term 0 regardless of exp.
- Pipeline: stage 1 registers term, term_valid and term_last on acceptance (in_valid & in_ready). Stage 2 adds term into acc when term_valid.
- States:
  - ACCUM: in_ready=1. Each accepted beat increments count.
    - Beat with count==NUM_PP-1 sets term_last and moves to DRAIN; in_ready is 0 in the following cycle.
  - DRAIN: in_ready=0. On the add of term_last, out_sum <= acc+term, out_valid <= 1, state → DONE. acc and count are cleared.
  - DONE: in_ready=0. out_sum and out_overflow are held stable while out_valid & !out_ready.
    - On out_valid & out_ready: out_valid <= 0, state → ACCUM, out_overflow <= 0.
- Latency: out_valid rises 2 cycles after the clock edge accepting the final beat. Minimum frame period is NUM_PP+3 cycles.
- in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.
- clear:
  - In ACCUM or DRAIN: acc, count and stage 1 are zeroed; state=ACCUM. Any beat offered in the same cycle is dropped.
  - In DONE: ignored; the pending sum is still delivered.
- rst mid-frame or mid-DONE: everything returns to reset values; the pending sum is lost.
- NUM_PP=1: ACCUM → DRAIN on the first accepted beat.

Optional Feature:
- Macro: PP_ACC_SATURATE_EN.
- Defined:
  - Each stage-2 add detects signed overflow, including term truncation.
  - On overflow, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and a sticky frame flag is set. Saturation persists for later adds in the frame, re-clamping as needed.
  - out_overflow = sticky flag, presented with out_sum.
- Undefined: plain two's-complement wrap; out_overflow is tied 0; no overflow logic is synthesised.

Test Plan:
- Default params, 9 beats of signed_pp=5'b01000, exp=0, out_ready=1 → out_sum=72, out_valid pulses 2 cycles after the 9th acceptance.
- Mixed frame: beat0 5'b11010/exp=3, beat1 5'b01111/exp=22, beats 2-8 zero (5'b00000/exp=7) → out_sum = -80 + 62914560 = 62914480.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid → out_sum and out_valid stable, in_ready=0, in_valid beats not accepted.
  - Release out_ready → handshake completes, in_ready=1 next cycle, next 9-beat frame sums correctly.
- Interruptions:
  - Assert rst after 4 beats → all outputs 0 next cycle; a following 9 beat frame of 5'b01000/exp=1 gives 144.
  - Repeat with clear instead of rst → same 144.
- Overflow, ACC_W=16, 9 beats of 5'b01111/exp=10 (15360 each):
  - With PP_ACC_SATURATE_EN: out_sum=32767, out_overflow=1; the flag clears after the handshake.
  - Without: out_sum=7168, out_overflow=0.
- Streaming: in_valid and out_ready held 1 for 3 frames of alternating-sign beats → 3 correct sums, no dropped or duplicated beats, in_ready low exactly in DRAIN and DONE.
